multicycle_controller: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath. Sequences one instruction over 3–5 steps: fetch, decode, execute, memory, writeback.
- Drives the datapath's mux selects and write enables. Drives the 2-bit ALUop into the existing ALU control decoder: 00 add, 01 sub, 10 use func, 11 slt.
- Handles a ready handshake with the shared instruction/data memory, with a timeout.

---
 rtl/multicycle_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for a multi-cycle MIPS datapath. Walks one instruction
//   through fetch / decode / execute / memory / writeback (3 to 5 steps)
//   and drives the datapath mux selects, write enables and the 2-bit ALUop.
//   Memory accesses wait on mem_ready and are aborted after MEM_TIMEOUT
//   wait cycles (MEM_TIMEOUT = 0 waits forever).
//
//   State table:
//     state  | code | meaning
//     IF     |  0   | fetch instruction, PC <= PC + 4 when memory is ready
//     ID     |  1   | decode, branch target into ALUOut
//     MEMADR |  2   | lw/sw address computation
//     MEMRD  |  3   | data memory read (waits on mem_ready)
//     MEMWB  |  4   | MDR written to rt
//     MEMWR  |  5   | data memory write (waits on mem_ready)
//     EX_R   |  6   | R-type ALU operation
//     WB_R   |  7   | ALUOut written to rd
//     BR     |  8   | beq compare, PC <= ALUOut when zero
//     JMP    |  9   | PC <= jump target
//     EX_I   | 10   | addi/slti ALU operation
//     WB_I   | 11   | ALUOut written to rt
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   opcode           IR[31:26]
//   zero             ALU zero flag
//   mem_ready        memory completed the current access this cycle
//   pc_en .. pc_src  datapath controls
//   illegal_op       one-cycle pulse on an unsupported opcode (in ID)
//   mem_err          one-cycle pulse on a memory wait timeout
//   state            current state code, for debug
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EX_R   = 4'd6,
    S_WB_R   = 4'd7,
    S_BR     = 4'd8,
    S_JMP    = 4'd9,
    S_EX_I   = 4'd10,
    S_WB_I   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam bit               L_TO_EN   = (MEM_TIMEOUT != 0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_waiting;
  logic             w_timeout;
  logic             w_illegal;

  assign w_waiting = ((r_state == S_IF) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                     && !mem_ready;
  assign w_timeout = L_TO_EN && w_waiting && (r_wait_cnt == L_TIMEOUT);

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_IF:     if (mem_ready) w_next = S_ID;
                else if (w_timeout) w_next = S_IF;
      S_ID: begin
        case (opcode)
          OP_RTYPE:       w_next = S_EX_R;
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_BEQ:         w_next = S_BR;
          OP_J:           w_next = S_JMP;
          OP_ADDI,
          OP_SLTI:        w_next = S_EX_I;
          default: begin
            w_next    = S_IF;
            w_illegal = 1'b1;
          end
        endcase
      end
      // MEMADR is only reached for lw or sw, so anything but lw is a store.
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
                else if (w_timeout) w_next = S_IF;
      S_MEMWB:  w_next = S_IF;
      S_MEMWR:  if (mem_ready || w_timeout) w_next = S_IF;
      S_EX_R:   w_next = S_WB_R;
      S_WB_R:   w_next = S_IF;
      S_BR:     w_next = S_IF;
      S_JMP:    w_next = S_IF;
      S_EX_I:   w_next = S_WB_I;
      S_WB_I:   w_next = S_IF;
      default:  w_next = S_IF;
    endcase
  end

  // A timeout in IF keeps the state at IF, so the counter is cleared
  // explicitly to start the retried fetch from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IF;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || w_timeout)
        r_wait_cnt <= '0;
      else if (w_waiting && (r_wait_cnt != '1))
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Outputs decode the current state; reset forces every control low.
  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    state      = 4'd0;
    if (!rst) begin
      state   = r_state;
      mem_err = w_timeout;
      case (r_state)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_ID: begin
          alu_src_b  = 2'b11;
          illegal_op = w_illegal;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_en     = zero;
        end
        S_JMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        S_EX_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
        end
        S_WB_I: begin
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (MEM_TIMEOUT = 3).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op, mem_err;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [16:0] w_ctl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .mem_err(mem_err),
    .state(state)
  );

  assign w_ctl = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, mem_err};

  function automatic logic [16:0] mk(
      input logic pe, input logic iod, input logic mr, input logic mw, input logic irw,
      input logic rd, input logic m2r, input logic rw, input logic asa,
      input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] ps,
      input logic ill, input logic err);
    return {pe, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ps, ill, err};
  endfunction

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_SLTI = 6'b001010, OP_BAD = 6'b111111;

  logic [16:0] C_ZERO, C_IF_RDY, C_IF_WAIT, C_IF_TO, C_ID, C_ID_ILL, C_MEMADR, C_MEMRD;
  logic [16:0] C_MEMWB, C_MEMWR, C_EXR, C_WBR, C_BR_T, C_BR_N, C_JMP, C_EXI_ADD;
  logic [16:0] C_EXI_SLT, C_WBI;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                     input logic [3:0] s, input logic [16:0] c);
    vecs.push_back('{r, o, z, m, s, c});
  endtask

  task automatic drive(input logic r, input logic [5:0] o, input logic z, input logic m);
    @(negedge clk);
    rst = r; opcode = o; zero = z; mem_ready = m;
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, got, want);
    end
  endtask

  task automatic sw_timeout(input bit rdy4, input int base);
    drive(1'b1, OP_SW, 1'b0, 1'b1);
    check("to_rst_state", base, 32'(state), 32'd0);
    drive(1'b0, OP_SW, 1'b0, 1'b1);
    check("to_if", base, 32'(state), 32'd0);
    drive(1'b0, OP_SW, 1'b0, 1'b1);
    check("to_id", base, 32'(state), 32'd1);
    drive(1'b0, OP_SW, 1'b0, 1'b1);
    check("to_memadr", base, 32'(state), 32'd2);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, OP_SW, 1'b0, (k == 3) && rdy4);
      check("to_wr_state", base + k, 32'(state), 32'd5);
      check("to_mem_write", base + k, 32'(mem_write), 32'd1);
      check("to_mem_err", base + k, 32'(mem_err), 32'((k == 3) && !rdy4));
    end
    drive(1'b0, OP_SW, 1'b0, 1'b0);
    check("to_back_if", base, 32'(state), 32'd0);
    check("to_back_ctl", base, 32'(w_ctl), 32'(C_IF_WAIT));
  endtask

  initial begin
    C_ZERO    = '0;
    C_IF_RDY  = mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    C_IF_WAIT = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    C_IF_TO   = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,1);
    C_ID      = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    C_ID_ILL  = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,0);
    C_MEMADR  = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    C_MEMRD   = mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    C_MEMWB   = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
    C_MEMWR   = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    C_EXR     = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    C_WBR     = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
    C_BR_T    = mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
    C_BR_N    = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
    C_JMP     = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0);
    C_EXI_ADD = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    C_EXI_SLT = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,0);
    C_WBI     = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);

    // reset 2 cycles, then fetch
    add(1, OP_R,    0, 1, 4'd0,  C_ZERO);
    add(1, OP_R,    0, 1, 4'd0,  C_ZERO);
    add(0, OP_R,    0, 1, 4'd0,  C_IF_RDY);
    // R-type
    add(0, OP_R,    0, 1, 4'd1,  C_ID);
    add(0, OP_R,    0, 1, 4'd6,  C_EXR);
    add(0, OP_R,    0, 1, 4'd7,  C_WBR);
    // lw with two wait cycles in MEMRD
    add(0, OP_LW,   0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_LW,   0, 1, 4'd1,  C_ID);
    add(0, OP_LW,   0, 1, 4'd2,  C_MEMADR);
    add(0, OP_LW,   0, 0, 4'd3,  C_MEMRD);
    add(0, OP_LW,   0, 0, 4'd3,  C_MEMRD);
    add(0, OP_LW,   0, 1, 4'd3,  C_MEMRD);
    add(0, OP_LW,   0, 1, 4'd4,  C_MEMWB);
    // beq taken / not taken
    add(0, OP_BEQ,  1, 1, 4'd0,  C_IF_RDY);
    add(0, OP_BEQ,  1, 1, 4'd1,  C_ID);
    add(0, OP_BEQ,  1, 1, 4'd8,  C_BR_T);
    add(0, OP_BEQ,  0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_BEQ,  0, 1, 4'd1,  C_ID);
    add(0, OP_BEQ,  0, 1, 4'd8,  C_BR_N);
    // j
    add(0, OP_J,    0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_J,    0, 1, 4'd1,  C_ID);
    add(0, OP_J,    0, 1, 4'd9,  C_JMP);
    // addi, slti
    add(0, OP_ADDI, 0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_ADDI, 0, 1, 4'd1,  C_ID);
    add(0, OP_ADDI, 0, 1, 4'd10, C_EXI_ADD);
    add(0, OP_ADDI, 0, 1, 4'd11, C_WBI);
    add(0, OP_SLTI, 0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_SLTI, 0, 1, 4'd1,  C_ID);
    add(0, OP_SLTI, 0, 1, 4'd10, C_EXI_SLT);
    add(0, OP_SLTI, 0, 1, 4'd11, C_WBI);
    // illegal opcode: one-cycle pulse in ID, back to IF
    add(0, OP_BAD,  0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_BAD,  0, 1, 4'd1,  C_ID_ILL);
    add(0, OP_SW,   0, 0, 4'd0,  C_IF_WAIT);
    // sw, no waits
    add(0, OP_SW,   0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_SW,   0, 1, 4'd1,  C_ID);
    add(0, OP_SW,   0, 1, 4'd2,  C_MEMADR);
    add(0, OP_SW,   0, 1, 4'd5,  C_MEMWR);
    // reset mid-instruction (would be in EX_R)
    add(0, OP_R,    0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_R,    0, 1, 4'd1,  C_ID);
    add(1, OP_R,    0, 1, 4'd0,  C_ZERO);
    // fetch timeout: 4th waiting cycle pulses mem_err, counter restarts
    add(0, OP_R,    0, 0, 4'd0,  C_IF_WAIT);
    add(0, OP_R,    0, 0, 4'd0,  C_IF_WAIT);
    add(0, OP_R,    0, 0, 4'd0,  C_IF_WAIT);
    add(0, OP_R,    0, 0, 4'd0,  C_IF_TO);
    add(0, OP_R,    0, 0, 4'd0,  C_IF_WAIT);
    add(0, OP_R,    0, 1, 4'd0,  C_IF_RDY);
    add(0, OP_R,    0, 1, 4'd1,  C_ID);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].mr);
      check("vec_state", i, 32'(state), 32'(vecs[i].st));
      check("vec_ctl",   i, 32'(w_ctl), 32'(vecs[i].ctl));
    end

    // store timeout, then store with ready arriving on the timeout cycle
    sw_timeout(1'b0, 100);
    sw_timeout(1'b1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
